// File: rtl/burst_mem_responder_if.sv
// Burst read/write request bundle shared by initiators and responders.
// The initiator owns requests and write data; the responder owns the rest.
`timescale 1ns/1ps
interface burst_mem_responder_if #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 32
);
  logic                     rd_burst_req;
  logic                     wr_burst_req;
  logic [9:0]               rd_burst_len;
  logic [9:0]               wr_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic [ADDR_BITS-1:0]     wr_burst_addr;
  logic                     rd_burst_data_valid;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     rd_burst_finish;
  logic                     wr_burst_finish;
  logic                     busy;

  modport master (
    output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    input  rd_burst_data_valid, wr_burst_data_req, rd_burst_data,
           rd_burst_finish, wr_burst_finish, busy
  );

  modport slave (
    input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    output rd_burst_data_valid, wr_burst_data_req, rd_burst_data,
           rd_burst_finish, wr_burst_finish, busy
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Burst responder backed by a word-addressed synchronous RAM; one burst at a time.
// Optional BURST_MEM_RESPONDER_WAIT_STATE_EN inserts LFSR-driven stall cycles.
`timescale 1ns/1ps
module burst_mem_responder #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 32,
  parameter int MEM_AW        = 10
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  burst_mem_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_FLUSH, S_RD, S_RD_FLUSH, S_FIN, S_DONE
  } state_t;

  state_t                   r_state;
  logic                     r_wr_first;
  logic [9:0]               r_len;
  logic [9:0]               r_cnt;
  logic [MEM_AW-1:0]        r_idx;
  logic                     r_wr_req;
  logic                     r_wr_cap;
  logic                     r_rd_en;
  logic                     r_rd_valid;
  logic [MEM_DATA_BITS-1:0] r_rd_data;
  logic                     r_wr_fin;
  logic                     r_rd_fin;
  logic                     r_busy;
  logic [MEM_DATA_BITS-1:0] r_mem [0:(1<<MEM_AW)-1];

  logic w_stall;
  logic w_both;
  logic w_pick_wr;
  logic w_unused_addr_bits;

`ifdef BURST_MEM_RESPONDER_WAIT_STATE_EN
  logic [15:0] r_lfsr;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  assign w_both    = bus.wr_burst_req & bus.rd_burst_req;
  assign w_pick_wr = bus.wr_burst_req & (~bus.rd_burst_req | r_wr_first);

  // Index bits above MEM_AW-1 wrap by design.
  assign w_unused_addr_bits = ^{bus.rd_burst_addr[ADDR_BITS-1:MEM_AW],
                                bus.wr_burst_addr[ADDR_BITS-1:MEM_AW]};

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_first <= 1'b1;
      r_len      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wr_req   <= 1'b0;
      r_wr_cap   <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_wr_fin   <= 1'b0;
      r_rd_fin   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // NOTE: pulses default low here and are raised by the case below; the later
      // non-blocking assignment in the same block wins.
      r_wr_fin   <= 1'b0;
      r_rd_fin   <= 1'b0;
      r_wr_cap   <= r_wr_req;
      r_rd_valid <= r_rd_en;
      if (r_rd_en) r_rd_data <= r_mem[r_idx];
      if (r_rd_en || r_wr_cap) r_idx <= r_idx + MEM_AW'(1);

      case (r_state)
        S_IDLE: begin
          if (bus.wr_burst_req || bus.rd_burst_req) begin
            if (w_both) r_wr_first <= ~r_wr_first;
            r_busy <= 1'b1;
            r_cnt  <= 10'd1;
            if (w_pick_wr) begin
              r_len <= bus.wr_burst_len;
              r_idx <= bus.wr_burst_addr[MEM_AW-1:0];
              if (bus.wr_burst_len == 10'd0) begin
                r_state  <= S_FIN;
                r_wr_fin <= 1'b1;
              end else begin
                r_state  <= S_WR;
                r_wr_req <= 1'b1;
              end
            end else begin
              r_len <= bus.rd_burst_len;
              r_idx <= bus.rd_burst_addr[MEM_AW-1:0];
              if (bus.rd_burst_len == 10'd0) begin
                r_state  <= S_FIN;
                r_rd_fin <= 1'b1;
              end else begin
                r_state <= S_RD;
                r_rd_en <= 1'b1;
              end
            end
          end
        end
        // r_cnt counts words already issued, including the current cycle's.
        S_WR: begin
          if (r_cnt == r_len) begin
            r_wr_req <= 1'b0;
            r_state  <= S_WR_FLUSH;
          end else if (w_stall) begin
            r_wr_req <= 1'b0;
          end else begin
            r_wr_req <= 1'b1;
            r_cnt    <= r_cnt + 10'd1;
          end
        end
        S_WR_FLUSH: begin
          r_state  <= S_FIN;
          r_wr_fin <= 1'b1;
        end
        S_RD: begin
          if (r_cnt == r_len) begin
            r_rd_en <= 1'b0;
            r_state <= S_RD_FLUSH;
          end else if (w_stall) begin
            r_rd_en <= 1'b0;
          end else begin
            r_rd_en <= 1'b1;
            r_cnt   <= r_cnt + 10'd1;
          end
        end
        S_RD_FLUSH: begin
          r_state  <= S_FIN;
          r_rd_fin <= 1'b1;
        end
        S_FIN: r_state <= S_DONE;
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately not reset, so it maps onto block RAM and
  // keeps its contents across a reset.
  always_ff @(posedge mem_clk) begin
    if (r_wr_cap) r_mem[r_idx] <= bus.wr_burst_data;
  end

  assign bus.wr_burst_data_req   = r_wr_req;
  assign bus.rd_burst_data_valid = r_rd_valid;
  assign bus.rd_burst_data       = r_rd_data;
  assign bus.wr_burst_finish     = r_wr_fin;
  assign bus.rd_burst_finish     = r_rd_fin;
  assign bus.busy                = r_busy;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder (default build, no wait states).
`timescale 1ns/1ps
module tb_burst_mem_responder;
  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  logic mem_clk = 1'b0;
  logic rst;
  always #5 mem_clk = ~mem_clk;

  burst_mem_responder_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

  burst_mem_responder #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .MEM_AW(10)) dut (
    .mem_clk (mem_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wr_words [$];

  int wr_req_cnt, wr_first, wr_last, wr_fin_cnt, wr_fin_at;
  int rd_val_cnt, rd_first, rd_last, rd_fin_cnt, rd_fin_at;
  bit busy_log [0:4095];

  function automatic logic [DW-1:0] pat(input int sel, input int k);
    logic [7:0]  b;
    logic [31:0] s;
    logic [31:0] kk;
    b  = k[7:0];
    s  = sel;
    kk = k;
    if (sel == 0) return {8{b}};
    return {s, kk};
  endfunction

  // Raises the enabled requests together in cycle T0 and runs until every
  // finish has been seen plus two cycles; cycle numbers are relative to T0.
  task automatic run_burst(input bit en_wr, input int wa, input int wn, input int wsel,
                           input bit en_rd, input int ra, input int rn);
    int t, kw, fin_max;
    bit data_pend, wr_drop, rd_drop, done, all_fin;
    logic [DW-1:0] e;
    wr_req_cnt = 0; wr_first = -1; wr_last = -1; wr_fin_cnt = 0; wr_fin_at = -1;
    rd_val_cnt = 0; rd_first = -1; rd_last = -1; rd_fin_cnt = 0; rd_fin_at = -1;
    wr_words.delete();
    @(negedge mem_clk);
    if (en_wr) begin
      for (int k = 0; k < wn; k++) begin
        wr_words.push_back(pat(wsel, k));
        model_mem[(wa + k) & (DEPTH-1)] = pat(wsel, k);
      end
      bus.wr_burst_addr = wa;
      bus.wr_burst_len  = wn[9:0];
      bus.wr_burst_req  = 1'b1;
    end
    if (en_rd) begin
      for (int k = 0; k < rn; k++) exp_q.push_back(model_mem[(ra + k) & (DEPTH-1)]);
      bus.rd_burst_addr = ra;
      bus.rd_burst_len  = rn[9:0];
      bus.rd_burst_req  = 1'b1;
    end
    t = 0; kw = 0; data_pend = 0; wr_drop = 0; rd_drop = 0; done = 0;
    while (!done) begin
      @(posedge mem_clk); #1;
      t++;
      if (data_pend && kw < wr_words.size()) begin
        bus.wr_burst_data = wr_words[kw];
        kw++;
      end
      if (wr_drop) bus.wr_burst_req = 1'b0;
      if (rd_drop) bus.rd_burst_req = 1'b0;
      @(negedge mem_clk);
      data_pend = bus.wr_burst_data_req;
      if (bus.wr_burst_data_req) begin
        wr_req_cnt++;
        if (wr_first < 0) wr_first = t;
        wr_last = t;
      end
      if (bus.rd_burst_data_valid) begin
        rd_val_cnt++;
        if (rd_first < 0) rd_first = t;
        rd_last = t;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: valid at T%0d with empty scoreboard", t);
        end else begin
          e = exp_q.pop_front();
          if (bus.rd_burst_data !== e) begin
            n_fail++;
            $display("FAIL rd_data T%0d: got %h want %h", t, bus.rd_burst_data, e);
          end
        end
      end
      if (bus.wr_burst_finish) begin wr_fin_cnt++; wr_fin_at = t; wr_drop = 1; end
      if (bus.rd_burst_finish) begin rd_fin_cnt++; rd_fin_at = t; rd_drop = 1; end
      busy_log[t] = bus.busy;
      all_fin = (!en_wr || wr_fin_cnt > 0) && (!en_rd || rd_fin_cnt > 0);
      fin_max = (wr_fin_at > rd_fin_at) ? wr_fin_at : rd_fin_at;
      if (all_fin && t >= fin_max + 2) done = 1;
      if (t >= 3000) begin
        n_checks++; n_fail++;
        $display("FAIL burst_timeout: no finish after %0d cycles", t);
        done = 1;
      end
    end
    bus.wr_burst_req = 1'b0;
    bus.rd_burst_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge mem_clk);
    rst = 1'b1;
    repeat (2) @(negedge mem_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mem_clk);
    n_checks++;
    if ({bus.busy, bus.rd_burst_data_valid, bus.wr_burst_data_req,
         bus.rd_burst_finish, bus.wr_burst_finish} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {bus.busy, bus.rd_burst_data_valid,
               bus.wr_burst_data_req, bus.rd_burst_finish, bus.wr_burst_finish});
    end
    n_checks++;
    if (bus.rd_burst_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", bus.rd_burst_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge mem_clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_write_128();
    run_burst(1, 32'h0200_0000, 128, 0, 0, 0, 0);
    n_checks++;
    if (wr_req_cnt != 128) begin n_fail++; $display("FAIL w128_req_cnt: got %0d want 128", wr_req_cnt); end
    n_checks++;
    if (wr_first != 1 || wr_last != 128) begin
      n_fail++; $display("FAIL w128_req_span: got T%0d..T%0d want T1..T128", wr_first, wr_last);
    end
    n_checks++;
    if (wr_fin_at != 130 || wr_fin_cnt != 1) begin
      n_fail++; $display("FAIL w128_finish: got T%0d x%0d want T130 x1", wr_fin_at, wr_fin_cnt);
    end
    n_checks++;
    if (busy_log[132] !== 1'b0) begin n_fail++; $display("FAIL w128_busy_T132: got %b want 0", busy_log[132]); end
  endtask

  task automatic test_read_128();
    run_burst(0, 0, 0, 0, 1, 32'h0200_0000, 128);
    n_checks++;
    if (rd_val_cnt != 128 || rd_first != 2 || rd_last != 129) begin
      n_fail++;
      $display("FAIL r128_valid: got %0d words T%0d..T%0d want 128 T2..T129", rd_val_cnt, rd_first, rd_last);
    end
    n_checks++;
    if (rd_fin_at != 130 || rd_fin_cnt != 1) begin
      n_fail++; $display("FAIL r128_finish: got T%0d x%0d want T130 x1", rd_fin_at, rd_fin_cnt);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL r128_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    run_burst(1, 1022, 4, 9, 0, 0, 0);
    n_checks++;
    if (wr_req_cnt != 4 || wr_fin_at != 6) begin
      n_fail++; $display("FAIL wrap_write: got %0d reqs fin T%0d want 4 fin T6", wr_req_cnt, wr_fin_at);
    end
    run_burst(0, 0, 0, 0, 1, 1022, 4);
    n_checks++;
    if (rd_val_cnt != 4 || rd_fin_at != 6) begin
      n_fail++; $display("FAIL wrap_read: got %0d words fin T%0d want 4 fin T6", rd_val_cnt, rd_fin_at);
    end
    run_burst(0, 0, 0, 0, 1, 0, 3);
    n_checks++;
    if (exp_q.size() != 0 || rd_val_cnt != 3) begin
      n_fail++; $display("FAIL wrap_low_read: got %0d words want 3", rd_val_cnt);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    run_burst(1, 200, 3, 3, 1, 100, 2);
    n_checks++;
    if (wr_first != 1 || wr_fin_at != 5) begin
      n_fail++; $display("FAIL arb1_write: got req T%0d fin T%0d want T1 T5", wr_first, wr_fin_at);
    end
    n_checks++;
    if (rd_first != 9 || rd_fin_at != 11 || rd_val_cnt != 2) begin
      n_fail++;
      $display("FAIL arb1_read: got valid T%0d fin T%0d n%0d want T9 T11 n2", rd_first, rd_fin_at, rd_val_cnt);
    end
    run_burst(1, 300, 2, 4, 1, 200, 3);
    n_checks++;
    if (rd_first != 2 || rd_fin_at != 5 || rd_val_cnt != 3) begin
      n_fail++;
      $display("FAIL arb2_read: got valid T%0d fin T%0d n%0d want T2 T5 n3", rd_first, rd_fin_at, rd_val_cnt);
    end
    n_checks++;
    if (wr_first != 8 || wr_fin_at != 11 || wr_req_cnt != 2) begin
      n_fail++;
      $display("FAIL arb2_write: got req T%0d fin T%0d n%0d want T8 T11 n2", wr_first, wr_fin_at, wr_req_cnt);
    end
    run_burst(0, 0, 0, 0, 1, 300, 2);
    n_checks++;
    if (exp_q.size() != 0 || rd_fin_at != 4) begin
      n_fail++; $display("FAIL arb2_readback: got fin T%0d want T4", rd_fin_at);
    end
  endtask

  task automatic test_len0();
    run_burst(1, 5, 0, 0, 0, 0, 0);
    n_checks++;
    if (wr_req_cnt != 0) begin n_fail++; $display("FAIL len0_reqs: got %0d want 0", wr_req_cnt); end
    n_checks++;
    if (wr_fin_at != 1 || wr_fin_cnt != 1) begin
      n_fail++; $display("FAIL len0_finish: got T%0d x%0d want T1 x1", wr_fin_at, wr_fin_cnt);
    end
    n_checks++;
    if (busy_log[1] !== 1'b1 || busy_log[3] !== 1'b0) begin
      n_fail++; $display("FAIL len0_busy: got T1=%b T3=%b want 1 0", busy_log[1], busy_log[3]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int k, t;
    bit saw_fin;
    run_burst(1, 500, 64, 7, 0, 0, 0);
    @(negedge mem_clk);
    bus.rd_burst_addr = 500;
    bus.rd_burst_len  = 10'd64;
    bus.rd_burst_req  = 1'b1;
    k = 0;
    t = 0;
    while (k < 20 && t < 200) begin
      @(negedge mem_clk);
      t++;
      if (bus.rd_burst_data_valid) begin
        n_checks++;
        if (bus.rd_burst_data !== model_mem[500 + k]) begin
          n_fail++; $display("FAIL mid_rd_data k%0d: got %h want %h", k, bus.rd_burst_data, model_mem[500 + k]);
        end
        k++;
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.rd_burst_data_valid, bus.rd_burst_finish} !== 3'b0 || bus.rd_burst_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy=%b valid=%b fin=%b data=%h want all 0",
               bus.busy, bus.rd_burst_data_valid, bus.rd_burst_finish, bus.rd_burst_data);
    end
    saw_fin = 0;
    repeat (2) begin
      @(negedge mem_clk);
      if (bus.rd_burst_finish) saw_fin = 1;
    end
    bus.rd_burst_req = 1'b0;
    rst = 1'b0;
    repeat (4) begin
      @(negedge mem_clk);
      if (bus.rd_burst_finish || bus.busy) saw_fin = 1;
    end
    n_checks++;
    if (saw_fin) begin n_fail++; $display("FAIL mid_reset_quiet: got finish/busy after reset want none"); end
    run_burst(0, 0, 0, 0, 1, 500, 64);
    n_checks++;
    if (rd_val_cnt != 64 || rd_fin_at != 66 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL mid_reread: got %0d words fin T%0d want 64 fin T66", rd_val_cnt, rd_fin_at);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_burst_req  = 1'b0;
    bus.wr_burst_req  = 1'b0;
    bus.rd_burst_len  = '0;
    bus.wr_burst_len  = '0;
    bus.rd_burst_addr = '0;
    bus.wr_burst_addr = '0;
    bus.wr_burst_data = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    test_reset();
    test_write_128();
    test_read_128();
    test_wrap();
    test_arbitration();
    test_len0();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Responder (slave) end of the team's burst read/write request interface; services bursts from an initiator such as the memory test pattern generator.
- Backs requests with an internal synchronous word-addressed RAM.
- Used as a DDR stand-in for simulation and for on-chip loopback bring-up.
- One burst in flight at a time; round-robin arbitration when read and write are requested together.

Parameters:
MEM_DATA_BITS, 64, data word width
ADDR_BITS, 32, request address width (word address)
MEM_AW, 10, RAM index width; depth = 2**MEM_AW words; address bits above MEM_AW-1 are ignored (wrap)

Ports:
mem_clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd_burst_req  in  1  read request, level, held until rd_burst_finish seen
wr_burst_req  in  1  write request, level, held until wr_burst_finish seen
rd_burst_len  in  10  read length in words
wr_burst_len  in  10  write length in words
rd_burst_addr  in  ADDR_BITS  read start word address
wr_burst_addr  in  ADDR_BITS  write start word address
rd_burst_data_valid  out  1  read data valid
wr_burst_data_req  out  1  one pulse per write word requested
rd_burst_data  out  MEM_DATA_BITS  read data
wr_burst_data  in  MEM_DATA_BITS  write data, presented by initiator the cycle after each wr_burst_data_req
rd_burst_finish  out  1  one-cycle read-done pulse
wr_burst_finish  out  1  one-cycle write-done pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: every output 0, state IDLE, counters 0, priority flag = write-first. RAM contents are not cleared.
- Reset mid-burst: outputs drop to 0 immediately (async). No finish pulse is issued. Partially written words remain in RAM.
- States: IDLE, WR, WR_FLUSH, RD, RD_FLUSH, FIN, DONE.
- IDLE, request accepted at cycle T0:
  - Latch address, length and direction.
  - If both requests are high: serve the direction opposite to the last one served, then toggle the flag. Otherwise serve whichever is high.
- Write, len N>0:
  - wr_burst_data_req=1 in cycles T1..TN (N consecutive cycles).
  - wr_burst_data sampled in T2..TN+1 and written to RAM[(addr+k) mod depth], k=0..N-1.
  - WR_FLUSH covers the final capture cycle.
  - FIN: wr_burst_finish=1 in cycle TN+2.
- Read, len N>0:
  - RAM read addresses issued T1..TN; 1-cycle RAM latency.
  - rd_burst_data_valid=1 with data in T2..TN+1.
  - rd_burst_finish=1 in cycle TN+2.
- Length 0: no data phase; go directly to FIN; finish pulses in T1.
- DONE: one cycle after FIN with requests ignored, because the initiator drops req one cycle after seeing finish. Then return to IDLE. A new request can be accepted in cycle TN+4.
- Word counter is 10 bits and counts to N. Max N=1023.
- Address increments modulo 2**MEM_AW; a burst crossing the top wraps to index 0.
- Request deasserted mid-burst: the burst still completes with its full length and a finish pulse.
- Requests arriving while busy are held pending and sampled only in IDLE.
- Read data is undefined for never-written locations in simulation (X allowed).

Optional Feature:
- Macro: BURST_MEM_RESPONDER_WAIT_STATE_EN.
- When defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) inserts stall cycles.
  - When LFSR bit0=1 in WR/RD, no wr_burst_data_req pulse or read address is issued that cycle, and the word counter holds.
  - Gaps in wr_burst_data_req and rd_burst_data_valid appear accordingly.
  - Total words, ordering and finish-after-last-word latency (finish 1 cycle after last valid, or 2 cycles after last data req) are unchanged.
- When not defined: no LFSR logic; timing is exactly as in Behaviour.

Test Plan:
- Write len 128 at addr 0x2000000, data = {8{k[7:0]}}:
  - 128 consecutive wr_burst_data_req pulses.
  - wr_burst_finish exactly at T130.
  - RAM[0..127] (index wraps from 0x2000000) hold the pattern.
- Read back the same burst: rd_burst_data_valid in T2..T129, data {8{k}} in order, rd_burst_finish at T130, no gaps.
- Write len 4 at addr 1022 (MEM_AW=10), then read len 4 at addr 1022: data appears in order from indices 1022, 1023, 0, 1.
- rd_burst_req and wr_burst_req raised in the same cycle after reset: write served first, then read. Repeat the simultaneous case and the order alternates (read first next time).
- Len 0 write: no wr_burst_data_req; wr_burst_finish in T1; busy low by T3.
- Assert rst in the middle of a 64-word read: outputs 0 immediately, no finish pulse. A fresh read afterwards returns the previously written data.
